// File: rtl/bus_master_sequencer.sv
// bus_master_sequencer
// Single initiator for the shared 8-bit peripheral bus. Requests arrive over a
// valid/ready handshake, are queued in a small FIFO of {we, addr, wdata}
// entries and are replayed onto the bus with fixed responder timing:
//   WRITE : one cycle, address + data + strobe
//   READ  : READ_LATENCY cycles with the address held, data sampled on the last edge
//   TURN  : one released cycle (idle address) while the responder lets go of the
//           data lines; RSP_VALID pulses here
// Ports:
//   CLK, RESET (async, active-low)
//   REQ_VALID/REQ_READY/REQ_WE/REQ_ADDR/REQ_WDATA : request handshake
//   RSP_VALID/RSP_DATA                            : read response pulse / held data
//   BUSY                                          : queue non-empty or transaction active
//   BUS_ADDR/BUS_DATA/BUS_WE                      : registered bus outputs, BUS_DATA tri-stated
module bus_master_sequencer #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned READ_LATENCY = 2,
  parameter logic [7:0]  IDLE_ADDR    = 8'hFF
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_WE,
  input  logic [7:0] REQ_ADDR,
  input  logic [7:0] REQ_WDATA,
  output logic       RSP_VALID,
  output logic [7:0] RSP_DATA,
  output logic       BUSY,
  output logic [7:0] BUS_ADDR,
  inout  wire  [7:0] BUS_DATA,
  output logic       BUS_WE
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned LW = $clog2(READ_LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_TURN
  } state_t;

  state_t state, state_n;

  logic          fifo_we    [FIFO_DEPTH];
  logic [7:0]    fifo_addr  [FIFO_DEPTH];
  logic [7:0]    fifo_wdata [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic          empty, full, push, pop, take;
  logic [LW-1:0] rd_cnt, rd_cnt_n;
  logic [7:0]    bus_wdata, bus_wdata_n, addr_n, rsp_data_n;
  logic          we_n, rsp_valid_n;

  assign empty     = (count == '0);
  assign full      = (count == CW'(FIFO_DEPTH));
  assign REQ_READY = !full;
  assign push      = REQ_VALID && !full;
  assign BUSY      = !empty || (state != S_IDLE);

  // The strobe register doubles as the output enable, so data is driven
  // exactly during the write cycle and released everywhere else.
  assign BUS_DATA = BUS_WE ? bus_wdata : 'z;

  always_comb begin
    state_n     = state;
    take        = 1'b0;
    pop         = 1'b0;
    rd_cnt_n    = rd_cnt;
    addr_n      = BUS_ADDR;
    we_n        = BUS_WE;
    bus_wdata_n = bus_wdata;
    rsp_valid_n = 1'b0;
    rsp_data_n  = RSP_DATA;

    case (state)
      S_READ: begin
        if (rd_cnt == '0) begin
          state_n     = S_TURN;
          addr_n      = IDLE_ADDR;
          we_n        = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_data_n  = BUS_DATA;
        end else begin
          rd_cnt_n = rd_cnt - LW'(1);
        end
      end
      default: begin
        // IDLE, WRITE and TURN all either launch the head request directly
        // or fall back to the idle bus.
        if (!empty) begin
          take = 1'b1;
        end else begin
          state_n = S_IDLE;
          addr_n  = IDLE_ADDR;
          we_n    = 1'b0;
        end
      end
    endcase

    if (take) begin
      pop         = 1'b1;
      addr_n      = fifo_addr[rd_ptr];
      we_n        = fifo_we[rd_ptr];
      bus_wdata_n = fifo_wdata[rd_ptr];
      rd_cnt_n    = LW'(READ_LATENCY - 1);
      state_n     = fifo_we[rd_ptr] ? S_WRITE : S_READ;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_cnt    <= '0;
      BUS_ADDR  <= IDLE_ADDR;
      BUS_WE    <= 1'b0;
      bus_wdata <= '0;
      RSP_VALID <= 1'b0;
      RSP_DATA  <= '0;
    end else begin
      state     <= state_n;
      rd_cnt    <= rd_cnt_n;
      BUS_ADDR  <= addr_n;
      BUS_WE    <= we_n;
      bus_wdata <= bus_wdata_n;
      RSP_VALID <= rsp_valid_n;
      RSP_DATA  <= rsp_data_n;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: entries are only read when count says they are valid.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_we[wr_ptr]    <= REQ_WE;
      fifo_addr[wr_ptr]  <= REQ_ADDR;
      fifo_wdata[wr_ptr] <= REQ_WDATA;
    end
  end

endmodule

// File: tb/tb_bus_master_sequencer.sv
// Testbench for bus_master_sequencer: directed scenarios with a registered
// responder on the shared bus (pull-up on the data lines, releases one cycle
// after the address leaves) plus a final random read/write mix.
module tb_bus_master_sequencer;

  logic       clk;
  logic       rst_n;
  logic       req_valid, req_ready, req_we;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid, busy, bus_we;
  logic [7:0] rsp_data, bus_addr;
  tri1  [7:0] bus_data;

  logic       resp_en;
  logic [7:0] resp_data;
  logic [7:0] mem [256];

  int checks = 0;
  int passed = 0;
  int contention = 0;
  int floating = 0;

  bus_master_sequencer #(
    .FIFO_DEPTH(4),
    .READ_LATENCY(2),
    .IDLE_ADDR(8'hFF)
  ) dut (
    .CLK(clk),
    .RESET(rst_n),
    .REQ_VALID(req_valid),
    .REQ_READY(req_ready),
    .REQ_WE(req_we),
    .REQ_ADDR(req_addr),
    .REQ_WDATA(req_wdata),
    .RSP_VALID(rsp_valid),
    .RSP_DATA(rsp_data),
    .BUSY(busy),
    .BUS_ADDR(bus_addr),
    .BUS_DATA(bus_data),
    .BUS_WE(bus_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered responder: every address except 0xFF decodes.
  assign bus_data = resp_en ? resp_data : 'z;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_en   <= 1'b0;
      resp_data <= 8'h00;
      for (int i = 0; i < 256; i++)
        mem[i] <= (i == 8'hD0) ? 8'h3C : (8'(i) ^ 8'h5A);
    end else begin
      resp_en   <= (bus_addr != 8'hFF) && !bus_we;
      resp_data <= mem[bus_addr];
      if (bus_we && bus_addr != 8'hFF) mem[bus_addr] <= bus_data;
    end
  end

  // Bus monitor: contention, and undriven data lines must float to the pull-up.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_we && resp_en) contention++;
      if (!bus_we && !resp_en && bus_data !== 8'hFF) floating++;
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    checks++; if (bus_addr !== 8'hFF) $display("FAIL reset_bus_addr: got %h want ff", bus_addr); else passed++;
    checks++; if (bus_we !== 1'b0) $display("FAIL reset_bus_we: got %b want 0", bus_we); else passed++;
    checks++; if (bus_data !== 8'hFF) $display("FAIL reset_bus_data: got %h want ff (released)", bus_data); else passed++;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else passed++;
    checks++; if (rsp_data !== 8'h00) $display("FAIL reset_rsp_data: got %h want 00", rsp_data); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'hD1; req_wdata = 8'h5A;
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (bus_addr !== 8'hFF) $display("FAIL wr_latency_addr: got %h want ff", bus_addr); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL wr_queued_busy: got %b want 1", busy); else passed++;
    @(negedge clk);
    checks++; if (bus_addr !== 8'hD1) $display("FAIL wr_addr: got %h want d1", bus_addr); else passed++;
    checks++; if (bus_data !== 8'h5A) $display("FAIL wr_data: got %h want 5a", bus_data); else passed++;
    checks++; if (bus_we !== 1'b1) $display("FAIL wr_we: got %b want 1", bus_we); else passed++;
    @(negedge clk);
    checks++; if (bus_addr !== 8'hFF) $display("FAIL wr_after_addr: got %h want ff", bus_addr); else passed++;
    checks++; if (bus_we !== 1'b0) $display("FAIL wr_after_we: got %b want 0", bus_we); else passed++;
    checks++; if (bus_data !== 8'hFF) $display("FAIL wr_after_data: got %h want ff (released)", bus_data); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL wr_after_busy: got %b want 0", busy); else passed++;
    checks++; if (mem[8'hD1] !== 8'h5A) $display("FAIL wr_responder_mem: got %h want 5a", mem[8'hD1]); else passed++;
  endtask

  task automatic test_single_read();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'hD0; req_wdata = 8'h00;
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (bus_addr !== 8'hFF) $display("FAIL rd_latency_addr: got %h want ff", bus_addr); else passed++;
    @(negedge clk);  // first read bus cycle
    checks++; if (bus_addr !== 8'hD0) $display("FAIL rd_addr1: got %h want d0", bus_addr); else passed++;
    checks++; if (bus_we !== 1'b0) $display("FAIL rd_we1: got %b want 0", bus_we); else passed++;
    checks++; if (bus_data !== 8'hFF) $display("FAIL rd_data_released: got %h want ff", bus_data); else passed++;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL rd_rsp_early1: got %b want 0", rsp_valid); else passed++;
    @(negedge clk);  // second read bus cycle, responder driving
    checks++; if (bus_addr !== 8'hD0) $display("FAIL rd_addr2: got %h want d0", bus_addr); else passed++;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL rd_rsp_early2: got %b want 0", rsp_valid); else passed++;
    @(negedge clk);  // turnaround cycle, third cycle of the transaction
    checks++; if (rsp_valid !== 1'b1) $display("FAIL rd_rsp_valid: got %b want 1", rsp_valid); else passed++;
    checks++; if (rsp_data !== 8'h3C) $display("FAIL rd_rsp_data: got %h want 3c", rsp_data); else passed++;
    checks++; if (bus_addr !== 8'hFF) $display("FAIL rd_turn_addr: got %h want ff", bus_addr); else passed++;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) $display("FAIL rd_rsp_pulse: got %b want 0", rsp_valid); else passed++;
    checks++; if (rsp_data !== 8'h3C) $display("FAIL rd_rsp_hold: got %h want 3c", rsp_data); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rd_busy_end: got %b want 0", busy); else passed++;
  endtask

  task automatic test_read_then_write();
    logic [7:0] exp_addr [5] = '{8'hD0, 8'hD0, 8'hFF, 8'hD1, 8'hFF};
    logic       exp_we   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       exp_rsp  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int c0;
    c0 = contention;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'hD0;
    @(negedge clk);
    req_we = 1'b1; req_addr = 8'hD1; req_wdata = 8'h11;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      checks++; if (bus_addr !== exp_addr[i]) $display("FAIL rtw_addr[%0d]: got %h want %h", i, bus_addr, exp_addr[i]); else passed++;
      checks++; if (bus_we !== exp_we[i]) $display("FAIL rtw_we[%0d]: got %b want %b", i, bus_we, exp_we[i]); else passed++;
      checks++; if (rsp_valid !== exp_rsp[i]) $display("FAIL rtw_rsp_valid[%0d]: got %b want %b", i, rsp_valid, exp_rsp[i]); else passed++;
      if (i == 2) begin
        checks++; if (rsp_data !== 8'h3C) $display("FAIL rtw_rsp_data: got %h want 3c", rsp_data); else passed++;
      end
      if (i == 3) begin
        checks++; if (bus_data !== 8'h11) $display("FAIL rtw_wdata: got %h want 11", bus_data); else passed++;
      end
    end
    checks++; if (contention !== c0) $display("FAIL rtw_contention: got %0d events want 0", contention - c0); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] got_a [6];
    logic [7:0] got_d [6];
    int cyc_of [6];
    int nw = 0, extra = 0, idx = 0;
    bit acc;
    logic busy_last = 1'bx, busy_after = 1'bx;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h10; req_wdata = 8'hA0;
    acc = req_ready;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus_we) begin
        if (nw < 6) begin
          got_a[nw] = bus_addr; got_d[nw] = bus_data; cyc_of[nw] = c;
          if (nw == 5) busy_last = busy;
          nw++;
        end else extra++;
      end else if (nw == 6 && c == cyc_of[5] + 1) begin
        busy_after = busy;
      end
      if (acc) begin
        idx++;
        if (idx < 6) begin
          req_addr = 8'(8'h10 + idx); req_wdata = 8'(8'hA0 + idx);
        end else req_valid = 1'b0;
      end
      acc = req_valid && req_ready;
    end
    req_valid = 1'b0;
    checks++; if (nw + extra !== 6) $display("FAIL b2b_count: got %0d writes want 6", nw + extra); else passed++;
    for (int k = 0; k < nw; k++) begin
      checks++; if (got_a[k] !== 8'(8'h10 + k)) $display("FAIL b2b_addr[%0d]: got %h want %h", k, got_a[k], 8'(8'h10 + k)); else passed++;
      checks++; if (got_d[k] !== 8'(8'hA0 + k)) $display("FAIL b2b_data[%0d]: got %h want %h", k, got_d[k], 8'(8'hA0 + k)); else passed++;
      checks++; if (cyc_of[k] != cyc_of[0] + k) $display("FAIL b2b_consecutive[%0d]: got cycle %0d want %0d", k, cyc_of[k], cyc_of[0] + k); else passed++;
    end
    checks++; if (busy_last !== 1'b1) $display("FAIL b2b_busy_last: got %b want 1", busy_last); else passed++;
    checks++; if (busy_after !== 1'b0) $display("FAIL b2b_busy_after: got %b want 0", busy_after); else passed++;
  endtask

  task automatic test_fifo_full();
    int accepted = 0, started = 0, nr = 0, idx = 0, bad_ready = 0;
    bit acc, saw_full = 0;
    logic [7:0] prev_addr;
    logic       prev_we;
    logic [7:0] exp;
    prev_addr = bus_addr; prev_we = bus_we;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h20;
    acc = req_ready;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (acc) accepted++;
      if (!bus_we && bus_addr != 8'hFF && (prev_addr == 8'hFF || prev_we)) started++;
      prev_addr = bus_addr; prev_we = bus_we;
      if (req_ready !== ((accepted - started) < 4)) bad_ready++;
      if (req_ready === 1'b0) saw_full = 1;
      if (rsp_valid) begin
        exp = 8'(8'h20 + nr) ^ 8'h5A;
        checks++; if (rsp_data !== exp) $display("FAIL full_rsp[%0d]: got %h want %h", nr, rsp_data, exp); else passed++;
        nr++;
      end
      if (acc) begin
        idx++;
        if (idx < 8) req_addr = 8'(8'h20 + idx); else req_valid = 1'b0;
      end
      acc = req_valid && req_ready;
    end
    req_valid = 1'b0;
    checks++; if (!saw_full) $display("FAIL full_ready_drop: got ready never low want low at 4 pending"); else passed++;
    checks++; if (bad_ready != 0) $display("FAIL full_ready_vs_pending: got %0d bad cycles want 0", bad_ready); else passed++;
    checks++; if (nr != 8) $display("FAIL full_rsp_count: got %0d want 8", nr); else passed++;
  endtask

  task automatic test_reset_mid_read();
    int viol = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'hD2;
    @(negedge clk);
    req_addr = 8'hD3;
    @(negedge clk);
    req_we = 1'b1; req_addr = 8'hD1; req_wdata = 8'h22;
    @(negedge clk);
    req_wdata = 8'h33;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);  // first read cycle of the second read, two writes queued
    checks++; if (bus_addr !== 8'hD3) $display("FAIL rst_pre_addr: got %h want d3", bus_addr); else passed++;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus_addr !== 8'hFF) $display("FAIL rst_async_addr: got %h want ff", bus_addr); else passed++;
    checks++; if (bus_we !== 1'b0) $display("FAIL rst_async_we: got %b want 0", bus_we); else passed++;
    checks++; if (req_ready !== 1'b1) $display("FAIL rst_async_ready: got %b want 1", req_ready); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_async_busy: got %b want 0", busy); else passed++;
    checks++; if (rsp_data !== 8'h00) $display("FAIL rst_async_rsp_data: got %h want 00", rsp_data); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || bus_addr !== 8'hFF || bus_we !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) viol++;
    end
    checks++; if (viol != 0) $display("FAIL rst_after_idle: got %0d active cycles want 0", viol); else passed++;
  endtask

  task automatic test_random();
    logic [7:0] rm [256];
    logic [7:0] q [$];
    logic [7:0] e;
    int issued = 0;
    bit acc = 0, done = 0;
    for (int i = 0; i < 256; i++) rm[i] = mem[i];
    req_valid = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        checks++;
        if (q.size() == 0) $display("FAIL rand_rsp_unexpected: got %h want none", rsp_data);
        else begin
          e = q.pop_front();
          if (rsp_data !== e) $display("FAIL rand_rsp: got %h want %h", rsp_data, e); else passed++;
        end
      end
      if (acc) begin
        if (req_we) rm[req_addr] = req_wdata; else q.push_back(rm[req_addr]);
        issued++;
      end
      if (issued < 200) begin
        if (acc || !req_valid) begin
          req_valid = ($urandom_range(0, 3) != 0);
          req_we    = 1'($urandom_range(0, 1));
          req_addr  = 8'(8'hD0 + $urandom_range(0, 3));
          req_wdata = 8'($urandom);
        end
      end else req_valid = 1'b0;
      acc = req_valid && req_ready;
      if (issued >= 200 && !acc && !busy) done = 1;
    end
    req_valid = 1'b0;
    checks++; if (!done) $display("FAIL rand_timeout: got %0d issued or still busy want 200 idle", issued); else passed++;
    checks++; if (q.size() != 0) $display("FAIL rand_missing_rsp: got %0d outstanding want 0", q.size()); else passed++;
    checks++; if (contention != 0) $display("FAIL bus_contention: got %0d events want 0", contention); else passed++;
    checks++; if (floating != 0) $display("FAIL bus_data_driven_unexpectedly: got %0d events want 0", floating); else passed++;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    test_reset();
    test_single_write();
    test_single_read();
    test_read_then_write();
    test_back_to_back();
    test_fifo_full();
    test_reset_mid_read();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
